// File: rtl/qeciphy_rx_seq_checker.sv
// rtl/qeciphy_rx_seq_checker.sv - RX AXI-Stream incrementing-sequence checker
//
// Purpose:
//   Sits on the QECIPHY receive stream and checks that received words form an
//   incrementing sequence. It hunts for lock and then counts accepted words and
//   mismatches. It also captures the first failing expected/received word pair.
//
// Ports:
//   ACLK            clock for all logic
//   rst_n           asynchronous active-low reset
//   enable          checker runs while high; low returns the FSM to IDLE
//   clear           single-cycle pulse that clears the statistics
//   RX_TDATA        received word
//   RX_TVALID       received word valid
//   RX_TREADY       always ready once out of reset
//   locked          sequence lock achieved
//   err_flag        sticky mismatch flag
//   error_count     saturating count of mismatches seen while locked
//   word_count      saturating count of beats accepted while locked
//   first_err_exp   expected word at the first mismatch
//   first_err_rcv   received word at the first mismatch
//   state           FSM state: 0 IDLE, 1 HUNT, 2 LOCKED

module qeciphy_rx_seq_checker #(
  parameter int DATA_WIDTH     = 64,
  parameter int LOCK_CNT       = 4,
  parameter int UNLOCK_CNT     = 8,
  parameter int ERR_CNT_WIDTH  = 32,
  parameter int WORD_CNT_WIDTH = 48
) (
  input  logic                      ACLK,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     RX_TDATA,
  input  logic                      RX_TVALID,
  output logic                      RX_TREADY,
  output logic                      locked,
  output logic                      err_flag,
  output logic [ERR_CNT_WIDTH-1:0]  error_count,
  output logic [WORD_CNT_WIDTH-1:0] word_count,
  output logic [DATA_WIDTH-1:0]     first_err_exp,
  output logic [DATA_WIDTH-1:0]     first_err_rcv,
  output logic [1:0]                state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_LAST = BW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                st;
  logic [DATA_WIDTH-1:0] expected;
  logic [GW-1:0]         good_cnt;
  logic [BW-1:0]         bad_cnt;

  logic                  beat;
  logic                  match;
  logic [GW-1:0]         good_inc;
  logic [BW-1:0]         bad_inc;

  assign beat     = RX_TVALID & RX_TREADY;
  assign match    = (RX_TDATA == expected);
  assign good_inc = good_cnt + GW'(1);
  assign bad_inc  = bad_cnt + BW'(1);
  assign state    = st;

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      RX_TREADY     <= 1'b0;
      locked        <= 1'b0;
      err_flag      <= 1'b0;
      error_count   <= '0;
      word_count    <= '0;
      first_err_exp <= '0;
      first_err_rcv <= '0;
      expected      <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
    end else begin
      RX_TREADY <= 1'b1;

      if (!enable) begin
        st     <= IDLE;
        locked <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            // Beats seen in IDLE are dropped; good_cnt==0 marks "not yet seeded".
            st       <= HUNT;
            good_cnt <= '0;
          end

          HUNT: begin
            if (beat) begin
              if ((good_cnt != '0) && match) begin
                good_cnt <= good_inc;
                expected <= expected + DATA_WIDTH'(1);
                if (good_inc == LOCK_LAST) begin
                  st      <= LOCKED;
                  locked  <= 1'b1;
                  bad_cnt <= '0;
                end
              end else begin
                // First beat, or a break in the run: restart from this word.
                expected <= RX_TDATA + DATA_WIDTH'(1);
                good_cnt <= GW'(1);
              end
            end
          end

          LOCKED: begin
            if (beat) begin
              // No resync while locked: a single corrupted word costs one error.
              expected <= expected + DATA_WIDTH'(1);
              if (word_count != '1) word_count <= word_count + WORD_CNT_WIDTH'(1);
              if (match) begin
                bad_cnt <= '0;
              end else begin
                bad_cnt  <= bad_inc;
                err_flag <= 1'b1;
                if (error_count != '1) error_count <= error_count + ERR_CNT_WIDTH'(1);
                if (!err_flag) begin
                  first_err_exp <= expected;
                  first_err_rcv <= RX_TDATA;
                end
                if (bad_inc == UNLOCK_LAST) begin
                  st       <= HUNT;
                  locked   <= 1'b0;
                  good_cnt <= '0;
                end
              end
            end
          end

          default: begin
            st     <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      // Placed last so it overrides any statistic update from a coincident beat.
      if (clear) begin
        err_flag      <= 1'b0;
        error_count   <= '0;
        word_count    <= '0;
        first_err_exp <= '0;
        first_err_rcv <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qeciphy_rx_seq_checker.sv
// tb/tb_qeciphy_rx_seq_checker.sv - scoreboard bench for qeciphy_rx_seq_checker

module tb_qeciphy_rx_seq_checker;

  localparam int DW = 64;
  localparam int EW = 32;
  localparam int WW = 48;

  logic          ACLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] RX_TDATA = '0;
  logic          RX_TVALID = 1'b0;
  logic          RX_TREADY;
  logic          locked;
  logic          err_flag;
  logic [EW-1:0] error_count;
  logic [WW-1:0] word_count;
  logic [DW-1:0] first_err_exp;
  logic [DW-1:0] first_err_rcv;
  logic [1:0]    state;

  always #5 ACLK = ~ACLK;

  qeciphy_rx_seq_checker dut (
    .ACLK          (ACLK),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear         (clear),
    .RX_TDATA      (RX_TDATA),
    .RX_TVALID     (RX_TVALID),
    .RX_TREADY     (RX_TREADY),
    .locked        (locked),
    .err_flag      (err_flag),
    .error_count   (error_count),
    .word_count    (word_count),
    .first_err_exp (first_err_exp),
    .first_err_rcv (first_err_rcv),
    .state         (state)
  );

  typedef struct {
    logic [1:0]    st;
    logic          lk;
    logic          ef;
    logic [EW-1:0] ec;
    logic [WW-1:0] wc;
    logic [DW-1:0] fe;
    logic [DW-1:0] fr;
    string         tag;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  logic mark = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: outputs seen at a falling edge reflect the rising edge that sampled
  // the cycle marked at the previous falling edge.
  initial begin
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge ACLK);
      if (pend) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=empty required=entry");
        end else begin
          e = sb.pop_front();
          cmp($sformatf("%s.state", e.tag), 64'(state), 64'(e.st));
          cmp($sformatf("%s.locked", e.tag), 64'(locked), 64'(e.lk));
          cmp($sformatf("%s.err_flag", e.tag), 64'(err_flag), 64'(e.ef));
          cmp($sformatf("%s.error_count", e.tag), 64'(error_count), 64'(e.ec));
          cmp($sformatf("%s.word_count", e.tag), 64'(word_count), 64'(e.wc));
          cmp($sformatf("%s.first_err_exp", e.tag), first_err_exp, e.fe);
          cmp($sformatf("%s.first_err_rcv", e.tag), first_err_rcv, e.fr);
          cmp($sformatf("%s.tready", e.tag), 64'(RX_TREADY), 64'd1);
        end
      end
      pend = mark;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [63:0] d, input logic clr,
                       input logic chk, input string tag);
    RX_TVALID = v;
    RX_TDATA  = d;
    clear     = clr;
    mark      = chk;
    if (chk) begin
      x.tag = tag;
      sb.push_back(x);
    end
    @(posedge ACLK);
    #1;
    RX_TVALID = 1'b0;
    clear     = 1'b0;
    mark      = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input string tag);
    drive(1'b1, d, 1'b0, 1'b1, tag);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".tready"}, 64'(RX_TREADY), 64'd0);
    cmp({tag, ".state"}, 64'(state), 64'd0);
    cmp({tag, ".locked"}, 64'(locked), 64'd0);
    cmp({tag, ".err_flag"}, 64'(err_flag), 64'd0);
    cmp({tag, ".error_count"}, 64'(error_count), 64'd0);
    cmp({tag, ".word_count"}, 64'(word_count), 64'd0);
    cmp({tag, ".first_err_exp"}, first_err_exp, 64'd0);
    cmp({tag, ".first_err_rcv"}, first_err_rcv, 64'd0);
  endtask

  initial begin
    x = '{st: 2'd0, lk: 1'b0, ef: 1'b0, ec: '0, wc: '0, fe: '0, fr: '0, tag: ""};

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge ACLK);
    #1;
    cmp("tready_after_reset", 64'(RX_TREADY), 64'd1);

    // Acquire lock on 0x10..0x13, then ten counted words
    enable = 1'b1;
    x.st = 2'd1;
    drive(1'b0, 64'h0, 1'b0, 1'b1, "enable");
    for (int i = 0; i < 3; i++) beat(64'h10 + 64'(i), "hunt");
    x.st = 2'd2; x.lk = 1'b1;
    beat(64'h13, "lock13");
    for (int i = 0; i < 10; i++) begin
      x.wc = 48'(i + 1);
      beat(64'h14 + 64'(i), "count");
    end
    x.wc = 48'd11; beat(64'h1E, "w1E");
    x.wc = 48'd12; beat(64'h1F, "w1F");

    // Single corrupted word while locked
    x.wc = 48'd13; beat(64'h20, "w20");
    x.wc = 48'd14; x.ec = 32'd1; x.ef = 1'b1; x.fe = 64'h21; x.fr = 64'hDEAD;
    beat(64'hDEAD, "dead");
    x.wc = 48'd15; beat(64'h22, "w22");
    x.wc = 48'd16; beat(64'h23, "w23");

    // Clear pulse with no beat
    x.wc = '0; x.ec = '0; x.ef = 1'b0; x.fe = '0; x.fr = '0;
    drive(1'b0, 64'h0, 1'b1, 1'b1, "clear");

    // Eight mismatches drop lock; capture is of the first one only
    x.ef = 1'b1; x.fe = 64'h24; x.fr = 64'h0;
    for (int k = 0; k < 8; k++) begin
      x.wc = 48'(k + 1);
      x.ec = 32'(k + 1);
      if (k == 7) begin x.st = 2'd1; x.lk = 1'b0; end
      beat(64'h0, "zeros");
    end
    for (int i = 0; i < 3; i++) beat(64'h100 + 64'(i), "rehunt");
    x.st = 2'd2; x.lk = 1'b1;
    beat(64'h103, "relock");

    // Back to HUNT via enable, then reseed on a broken run
    enable = 1'b0; x.st = 2'd0; x.lk = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b1, "dis1");
    enable = 1'b1; x.st = 2'd1;
    drive(1'b0, 64'h0, 1'b0, 1'b1, "ren1");
    beat(64'd5, "h5");
    beat(64'd6, "h6");
    beat(64'd9, "h9");
    beat(64'd10, "h10");
    beat(64'd11, "h11");
    x.st = 2'd2; x.lk = 1'b1;
    beat(64'd12, "h12");

    // Wrap through all-ones with valid gaps
    enable = 1'b0; x.st = 2'd0; x.lk = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b1, "dis2");
    enable = 1'b1; x.st = 2'd1;
    drive(1'b0, 64'h0, 1'b0, 1'b1, "ren2");
    beat(64'hFFFF_FFFF_FFFF_FFFA, "hFA");
    beat(64'hFFFF_FFFF_FFFF_FFFB, "hFB");
    beat(64'hFFFF_FFFF_FFFF_FFFC, "hFC");
    x.st = 2'd2; x.lk = 1'b1;
    beat(64'hFFFF_FFFF_FFFF_FFFD, "lockFD");
    x.wc = 48'd9;  beat(64'hFFFF_FFFF_FFFF_FFFE, "wFE");
    for (int g = 0; g < 3; g++) drive(1'b0, 64'h1234, 1'b0, 1'b1, "gap1");
    x.wc = 48'd10; beat(64'hFFFF_FFFF_FFFF_FFFF, "wFF");
    for (int g = 0; g < 3; g++) drive(1'b0, 64'h0, 1'b0, 1'b1, "gap2");
    x.wc = 48'd11; beat(64'h0, "wrap0");
    for (int g = 0; g < 3; g++) drive(1'b0, 64'h0, 1'b0, 1'b1, "gap3");
    x.wc = 48'd12; beat(64'h1, "wrap1");

    // Clear coincident with a mismatching beat; expected still advances
    x.wc = '0; x.ec = '0; x.ef = 1'b0; x.fe = '0; x.fr = '0;
    drive(1'b1, 64'h55, 1'b1, 1'b1, "clr_mis");
    x.wc = 48'd1; beat(64'h3, "after_clr");

    // Disable mid-stream: beat on that edge is ignored, stats held
    enable = 1'b0; x.st = 2'd0; x.lk = 1'b0;
    beat(64'h4, "dis_beat");
    enable = 1'b1; x.st = 2'd1;
    drive(1'b0, 64'h0, 1'b0, 1'b1, "ren3");
    beat(64'h40, "seed40");

    // Asynchronous reset pulse mid-cycle
    @(negedge ACLK);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    #1;
    rst_n = 1'b1;
    #1;
    cmp("tready_before_edge", 64'(RX_TREADY), 64'd0);
    @(posedge ACLK);
    #1;
    cmp("tready_after_release", 64'(RX_TREADY), 64'd1);
    cmp("state_after_release", 64'(state), 64'd1);

    repeat (3) @(posedge ACLK);
    cmp("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qeciphy_rx_seq_checker.md
Name: qeciphy_rx_seq_checker

Overview:
Downstream consumer of the QECIPHY receive AXI-Stream port in example designs. Checks that received words form the incrementing sequence sent by the TX traffic generator. Acquires sequence lock, counts accepted words and mismatches, and captures the first failing word pair. Results are exposed for ILA/VIO probing and LED status.

Parameters:
DATA_WIDTH, 64, width of RX_TDATA and the expected-word register.
LOCK_CNT, 4, consecutive in-sequence beats required to declare lock (>=2).
UNLOCK_CNT, 8, consecutive mismatching beats that drop lock (>=1).
ERR_CNT_WIDTH, 32, width of the saturating error counter.
WORD_CNT_WIDTH, 48, width of the saturating word counter.

Ports:
ACLK  in  1  clock; all logic is in this domain.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  level; checker runs while high.
clear  in  1  synchronous pulse; clears statistics.
RX_TDATA  in  DATA_WIDTH  received word from QECIPHY.
RX_TVALID  in  1  received word valid.
RX_TREADY  out  1  ready to QECIPHY.
locked  out  1  sequence lock achieved.
err_flag  out  1  sticky: at least one mismatch since the last clear or reset.
error_count  out  ERR_CNT_WIDTH  mismatches counted while locked (saturating).
word_count  out  WORD_CNT_WIDTH  beats accepted while locked (saturating).
first_err_exp  out  DATA_WIDTH  expected value at the first mismatch.
first_err_rcv  out  DATA_WIDTH  received value at the first mismatch.
state  out  2  FSM state: 0 IDLE, 1 HUNT, 2 LOCKED.

Behaviour:
- Reset: every output and internal register is 0, and the FSM is IDLE.
- RX_TREADY is registered. It is 0 in reset and 1 from the first ACLK edge after rst_n deasserts. It does not depend on enable or state.
- A beat is RX_TVALID & RX_TREADY. Non-beat cycles change no state or counter.
- All outputs are registered. Each output updates on the edge that samples the beat or the control input.
- Expected-word arithmetic is modulo 2^DATA_WIDTH, so all-ones is followed by 0.
- IDLE: beats are discarded. Go to HUNT on the edge where enable=1.
- HUNT, seeding:
  - The first beat after entering HUNT seeds expected <= data+1 and good_cnt <= 1.
  - A later beat equal to expected increments good_cnt and expected.
  - A later beat not equal to expected re-seeds: expected <= data+1, good_cnt <= 1.
  - Mismatches in HUNT are not counted as errors.
- HUNT to LOCKED: when a matching beat makes good_cnt reach LOCK_CNT, go to LOCKED. locked is 1 from that edge. The beat that completes lock is not counted in word_count.
- LOCKED, every beat:
  - Increment word_count (saturating).
  - Always set expected <= expected+1. There is no resync, so one corrupted word gives exactly one error.
  - Match: bad_cnt <= 0.
  - Mismatch: increment error_count (saturating at all-ones), set err_flag, increment bad_cnt.
  - If err_flag was 0 before this mismatch, capture first_err_exp/first_err_rcv. Later mismatches do not overwrite the capture.
- LOCKED to HUNT: when bad_cnt reaches UNLOCK_CNT, go to HUNT and set locked <= 0. The next beat re-seeds. Statistics are held.
- enable=0 in any state: go to IDLE next edge and set locked <= 0. Statistics are held. A beat on that edge is ignored.
- clear=1: on that edge, zero error_count, word_count, err_flag and first_err_*. Do not change FSM state, expected, good_cnt or bad_cnt.
- clear coincident with a LOCKED beat: clear wins, and that beat's word/error contribution is dropped.
- Saturation: counters stay at all-ones until clear or reset.

Test Plan:
- Reset, enable=1, send 0x10,0x11,0x12,0x13 back-to-back -> locked=1 and state=2 on the edge sampling 0x13; word_count=0. Then 0x14..0x1D -> word_count=10, error_count=0.
- Locked at expected 0x20; send 0x20, 0xDEAD, 0x22, 0x23 -> error_count=1, err_flag=1, first_err_exp=0x21, first_err_rcv=0xDEAD, locked stays 1.
- Locked; send 8 consecutive 0x0 words -> locked drops on the 8th and state=1, error_count=8. Then 0x100..0x103 -> relock.
- HUNT; send 5,6,9,10,11,12 -> lock on 12, not on 6/9; no errors counted.
- Lock with expected 0xFFFF_FFFF_FFFF_FFFE; send ...FE, ...FF, 0x0, 0x1 -> no errors; RX_TVALID gaps of 3 cycles change nothing. Then clear coincident with a mismatching beat -> error_count=0, err_flag=0.
- Deassert enable mid-stream -> state=0, locked=0 next edge, counters held. Async rst_n pulse mid-stream -> all outputs 0 immediately; RX_TREADY returns to 1 one edge after release.
